imm_li_encoder: RTL and testbench
=================================

// Module: imm_li_encoder
// PURPOSE
//   Inverse of the immediate extender: takes a 32-bit constant plus a destination
//   register and emits the shortest MIPS instruction sequence (1 or 2 words) that
//   loads it. Used by the self-test / boot instruction generator that feeds
//   programs into IM. Valid/ready on both sides; one constant in flight at a time.
// PARAMETERS
//   ADDIU_EN  1   1: sign-fitting constants use addiu; 0: addiu route disabled
//   CNT_W     16  width of the words-emitted counter (wraps)
// PORTS
//   clk        in   1      clock, all state on rising edge
//   reset_n    in   1      asynchronous, active-low reset
//   in_valid   in   1      request valid
//   in_ready   out  1      encoder can accept a request
//   in_rt      in   5      destination register number
//   in_imm32   in   32     constant to load
//   out_valid  out  1      out_instr valid
//   out_ready  in   1      consumer takes out_instr this cycle
//   out_instr  out  32     encoded instruction word
//   out_last   out  1      word is the final one of its sequence
//   word_cnt   out  CNT_W  total words handed off (out_valid & out_ready)
// BEHAVIOUR
//   Reset (async, reset_n=0): state IDLE, in_ready=1, out_valid=0, out_instr=0,
//     out_last=0, word_cnt=0. Reset mid-sequence drops the pending word(s).
//   FSM: IDLE -> EMIT1 on in_valid&in_ready (latch rt/imm, pick route).
//     EMIT1 -> IDLE on out_ready if single-word; -> EMIT2 on out_ready if pair.
//     EMIT2 -> IDLE on out_ready. in_ready = (state==IDLE), no bypass.
//   Latency: request accepted in cycle N -> out_valid in N+1. Next request can be
//     accepted the cycle after the last word's handshake (min 2 cycles/constant).
//   Output hold: while out_valid & !out_ready, out_instr/out_last stay unchanged.
//   Route selection on latched hi=imm[31:16], lo=imm[15:0], first match wins:
//     rt==0                              -> single nop 32'h0000_0000
//     ADDIU_EN & imm[31:15] all equal    -> addiu {6'h09,5'd0,rt,lo}
//     hi==16'h0000                       -> ori   {6'h0D,5'd0,rt,lo}
//     lo==16'h0000                       -> lui   {6'h0F,5'd0,rt,hi}
//     otherwise pair: lui {6'h0F,5'd0,rt,hi}, then ori {6'h0D,rt,rt,lo}
//   out_last=1 on every single word and on the ori of a pair; 0 on the pair's lui.
//   With ADDIU_EN=0, negative sign-fitting values (e.g. 0xFFFF8000) take pair route.
//   word_cnt increments by 1 per output handshake, wraps 2^CNT_W-1 -> 0.
//   in_valid while !in_ready is ignored (request must be held by sender).
//   X on in_* when !in_valid must not propagate to outputs.
// TESTING
//   rt=8, imm=0x00001234 -> one word 0x24081234, out_last=1, word_cnt=1
//   rt=9, imm=0xFFFF8000 -> 0x24098000; ADDIU_EN=0 -> 0x3C09FFFF then 0x35298000
//   rt=9, imm=0x0000ABCD -> 0x3409ABCD; rt=10, imm=0x12340000 -> 0x3C0A1234
//   rt=10, imm=0xDEADBEEF, out_ready low 3 cycles -> 0x3C0ADEAD held stable
//     (out_last=0), then 0x354ABEEF (out_last=1); in_ready low throughout
//   rt=0, imm=0xDEADBEEF -> single 0x00000000, out_last=1
//   reset_n low after pair's first handshake -> out_valid=0 immediately, in_ready=1,
//     word_cnt=0; CNT_W=2 with 5 words -> word_cnt wraps to 1

Source files
------------

// File: rtl/imm_li_encoder.sv
// imm_li_encoder: turns a 32-bit constant plus a destination register into the
// shortest MIPS load-immediate sequence (nop, addiu, ori, lui, or lui+ori pair).
// Valid/ready on both sides with one constant in flight at a time.
module imm_li_encoder #(
  parameter bit ADDIU_EN = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rt,
  input  logic [31:0]      in_imm32,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_last,
  output logic [CNT_W-1:0] word_cnt
);

  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_t;

  state_t      state;
  logic [31:0] second_q;

  logic [31:0] first_w;
  logic [31:0] second_w;
  logic        pair;
  logic [15:0] hi;
  logic [15:0] lo;
  logic        sign_fit;

  assign hi       = in_imm32[31:16];
  assign lo       = in_imm32[15:0];
  // Upper 17 bits all equal means the value survives a 16-bit sign extension.
  assign sign_fit = (&in_imm32[31:15]) | ~(|in_imm32[31:15]);

  // Route selection on the offered request; only sampled on acceptance, so
  // unknown inputs while in_valid is low never reach the output registers.
  always_comb begin
    first_w  = 32'h0000_0000;
    second_w = 32'h0000_0000;
    pair     = 1'b0;
    if (in_rt == 5'd0) begin
      first_w = 32'h0000_0000;
    end else if (ADDIU_EN && sign_fit) begin
      first_w = {OP_ADDIU, 5'd0, in_rt, lo};
    end else if (hi == 16'h0000) begin
      first_w = {OP_ORI, 5'd0, in_rt, lo};
    end else if (lo == 16'h0000) begin
      first_w = {OP_LUI, 5'd0, in_rt, hi};
    end else begin
      first_w  = {OP_LUI, 5'd0, in_rt, hi};
      second_w = {OP_ORI, in_rt, in_rt, lo};
      pair     = 1'b1;
    end
  end

  assign in_ready = (state == IDLE);

  // Sequencing FSM with registered output word, last flag and valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_instr <= 32'h0000_0000;
      out_last  <= 1'b0;
      second_q  <= 32'h0000_0000;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state     <= EMIT1;
            out_valid <= 1'b1;
            out_instr <= first_w;
            out_last  <= ~pair;
            second_q  <= second_w;
          end
        end
        EMIT1: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end else begin
              state     <= EMIT2;
              out_instr <= second_q;
              out_last  <= 1'b1;
            end
          end
        end
        EMIT2: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Count every word handed to the consumer; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_cnt <= '0;
    end else if (out_valid && out_ready) begin
      word_cnt <= word_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_li_encoder.sv
// Directed bench for imm_li_encoder: three instances (default, addiu disabled,
// 2-bit counter) selected one at a time through a shared stimulus path.
module tb_imm_li_encoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [4:0]  in_rt;
  logic [31:0] in_imm32;
  logic        out_ready;
  int          sel;

  logic        rdy0, rdy1, rdy2;
  logic        ov0, ov1, ov2;
  logic [31:0] oi0, oi1, oi2;
  logic        ol0, ol1, ol2;
  logic [15:0] wc0, wc1;
  logic [1:0]  wc2;

  logic        m_in_ready;
  logic        m_out_valid;
  logic [31:0] m_out_instr;
  logic        m_out_last;
  logic [15:0] m_cnt;

  int n_vec = 0;
  int n_bad = 0;
  int exp_cnt[3];
  int cnt_mod[3] = '{65536, 65536, 4};

  always #5 clk = ~clk;

  imm_li_encoder dut0 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid && sel == 0), .in_ready(rdy0),
    .in_rt(in_rt), .in_imm32(in_imm32),
    .out_valid(ov0), .out_ready(out_ready && sel == 0),
    .out_instr(oi0), .out_last(ol0), .word_cnt(wc0)
  );

  imm_li_encoder #(.ADDIU_EN(1'b0)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid && sel == 1), .in_ready(rdy1),
    .in_rt(in_rt), .in_imm32(in_imm32),
    .out_valid(ov1), .out_ready(out_ready && sel == 1),
    .out_instr(oi1), .out_last(ol1), .word_cnt(wc1)
  );

  imm_li_encoder #(.CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid && sel == 2), .in_ready(rdy2),
    .in_rt(in_rt), .in_imm32(in_imm32),
    .out_valid(ov2), .out_ready(out_ready && sel == 2),
    .out_instr(oi2), .out_last(ol2), .word_cnt(wc2)
  );

  always_comb begin
    m_in_ready  = rdy0;
    m_out_valid = ov0;
    m_out_instr = oi0;
    m_out_last  = ol0;
    m_cnt       = wc0;
    if (sel == 1) begin
      m_in_ready = rdy1; m_out_valid = ov1; m_out_instr = oi1; m_out_last = ol1; m_cnt = wc1;
    end else if (sel == 2) begin
      m_in_ready = rdy2; m_out_valid = ov2; m_out_instr = oi2; m_out_last = ol2; m_cnt = {14'd0, wc2};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_cnt(input string name);
    check(name, {16'd0, m_cnt}, 32'(exp_cnt[sel] % cnt_mod[sel]));
  endtask

  // Offer one request with out_ready held high and check every word.
  task automatic run_vec(input int s, input logic [4:0] rt, input logic [31:0] imm,
                         input bit is_pair, input logic [31:0] w0, input logic [31:0] w1,
                         input string tag);
    int waited;
    sel = s;
    @(negedge clk);
    waited = 0;
    while (!m_in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!m_in_ready) begin
      check({tag, " in_ready timeout"}, 32'(m_in_ready), 32'd1);
      return;
    end
    in_valid  = 1'b1;
    in_rt     = rt;
    in_imm32  = imm;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_rt    = 'x;
    in_imm32 = 'x;
    check({tag, " valid0"}, 32'(m_out_valid), 32'd1);
    check({tag, " word0"}, m_out_instr, w0);
    check({tag, " last0"}, 32'(m_out_last), 32'(!is_pair));
    @(posedge clk); #1;
    exp_cnt[s]++;
    if (is_pair) begin
      check({tag, " valid1"}, 32'(m_out_valid), 32'd1);
      check({tag, " word1"}, m_out_instr, w1);
      check({tag, " last1"}, 32'(m_out_last), 32'd1);
      @(posedge clk); #1;
      exp_cnt[s]++;
    end
    check({tag, " idle valid"}, 32'(m_out_valid), 32'd0);
    check({tag, " idle ready"}, 32'(m_in_ready), 32'd1);
    check_cnt({tag, " word_cnt"});
  endtask

  typedef struct {
    int          s;
    logic [4:0]  rt;
    logic [31:0] imm;
    bit          is_pair;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    tbl[0]  = '{0, 5'd8,  32'h0000_1234, 1'b0, 32'h2408_1234, 32'h0};
    tbl[1]  = '{0, 5'd9,  32'hFFFF_8000, 1'b0, 32'h2409_8000, 32'h0};
    tbl[2]  = '{1, 5'd9,  32'hFFFF_8000, 1'b1, 32'h3C09_FFFF, 32'h3529_8000};
    tbl[3]  = '{0, 5'd9,  32'h0000_ABCD, 1'b0, 32'h3409_ABCD, 32'h0};
    tbl[4]  = '{0, 5'd10, 32'h1234_0000, 1'b0, 32'h3C0A_1234, 32'h0};
    tbl[5]  = '{0, 5'd0,  32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 32'h0};
    tbl[6]  = '{0, 5'd10, 32'hDEAD_BEEF, 1'b1, 32'h3C0A_DEAD, 32'h354A_BEEF};
    tbl[7]  = '{0, 5'd3,  32'h0000_7FFF, 1'b0, 32'h2403_7FFF, 32'h0};
    tbl[8]  = '{1, 5'd3,  32'h0000_7FFF, 1'b0, 32'h3403_7FFF, 32'h0};
    tbl[9]  = '{0, 5'd31, 32'hFFFF_FFFF, 1'b0, 32'h241F_FFFF, 32'h0};
    tbl[10] = '{1, 5'd31, 32'hFFFF_FFFF, 1'b1, 32'h3C1F_FFFF, 32'h37FF_FFFF};
    tbl[11] = '{0, 5'd5,  32'h0001_0000, 1'b0, 32'h3C05_0001, 32'h0};
    tbl[12] = '{0, 5'd5,  32'h0000_8000, 1'b0, 32'h3405_8000, 32'h0};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_rt     = 'x;
    in_imm32  = 'x;
    out_ready = 1'b0;
    sel       = 0;
    exp_cnt   = '{0, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 32'(m_in_ready), 32'd1);
    check("reset out_valid", 32'(m_out_valid), 32'd0);
    check("reset out_instr", m_out_instr, 32'd0);
    check("reset out_last", 32'(m_out_last), 32'd0);
    check("reset word_cnt", {16'd0, m_cnt}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Idle with in_valid low must not start anything.
    repeat (3) @(posedge clk);
    #1;
    check("idle no valid", 32'(m_out_valid), 32'd0);

    for (int i = 0; i < 13; i++) begin
      run_vec(tbl[i].s, tbl[i].rt, tbl[i].imm, tbl[i].is_pair, tbl[i].w0, tbl[i].w1,
              $sformatf("vec%0d", i));
    end

    // Consumer stalls the lui of a pair for three cycles; a second request
    // is offered meanwhile and must be ignored.
    sel = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_rt     = 5'd10;
    in_imm32  = 32'hDEAD_BEEF;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_rt    = 5'd4;
    in_imm32 = 32'h0000_0001;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("stall%0d valid", c), 32'(m_out_valid), 32'd1);
      check($sformatf("stall%0d word", c), m_out_instr, 32'h3C0A_DEAD);
      check($sformatf("stall%0d last", c), 32'(m_out_last), 32'd0);
      check($sformatf("stall%0d in_ready", c), 32'(m_in_ready), 32'd0);
      @(posedge clk); #1;
    end
    check("stall hold word", m_out_instr, 32'h3C0A_DEAD);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    exp_cnt[0]++;
    check("stall word1", m_out_instr, 32'h354A_BEEF);
    check("stall last1", 32'(m_out_last), 32'd1);
    check("stall in_ready1", 32'(m_in_ready), 32'd0);
    @(posedge clk); #1;
    exp_cnt[0]++;
    check("stall done valid", 32'(m_out_valid), 32'd0);
    check("stall done ready", 32'(m_in_ready), 32'd1);
    check_cnt("stall word_cnt");

    // Asynchronous reset after the first handshake of a pair.
    @(negedge clk);
    in_valid  = 1'b1;
    in_rt     = 5'd7;
    in_imm32  = 32'h1234_5678;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rst word0", m_out_instr, 32'h3C07_1234);
    @(posedge clk); #1;
    check("rst word1", m_out_instr, 32'h34E7_5678);
    out_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("rst out_valid", 32'(m_out_valid), 32'd0);
    check("rst in_ready", 32'(m_in_ready), 32'd1);
    check("rst word_cnt", {16'd0, m_cnt}, 32'd0);
    exp_cnt = '{0, 0, 0};
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst still idle", 32'(m_out_valid), 32'd0);

    // Five words through the 2-bit counter instance: 5 mod 4 = 1.
    for (int i = 0; i < 5; i++) begin
      run_vec(2, 5'(i + 1), 32'h0000_0010 + 32'(i), 1'b0,
              32'h2400_0010 + (32'(i + 1) << 16) + 32'(i), 32'h0,
              $sformatf("wrap%0d", i));
    end
    sel = 2;
    #1;
    check("wrap final word_cnt", {16'd0, m_cnt}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
